memory_buffer_queue: RTL and testbench

- Parametrised successor to the single-register MBR: a DEPTH-entry FIFO of DATA_W-bit words between the memory data bus and the CPU datapath.
- Valid/ready handshakes on both sides, a synchronous flush, and occupancy/status outputs.
- Absorbs memory-read bursts while the datapath stalls, so the memory side never has to drop a word.

---
 rtl/mbq_pkg.sv | 18 +
 rtl/mbq_ptr.sv | 43 ++++
 rtl/memory_buffer_queue.sv | 120 ++++++++++++
 tb/tb_memory_buffer_queue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mbq_pkg.sv
// Shared constants and types for the memory buffer queue.
// Contents:
//   MBQ_DATA_W / MBQ_DEPTH  default word width and queue depth
//   mbq_ptr_w()             pointer width for a given depth (never below 1)
//   mbq_word_t              default-width data word
package mbq_pkg;

  localparam int unsigned MBQ_DATA_W = 16;
  localparam int unsigned MBQ_DEPTH  = 4;

  // A depth of 1 would give $clog2 == 0, which is not a legal vector width.
  function automatic int unsigned mbq_ptr_w(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  typedef logic [MBQ_DATA_W-1:0] mbq_word_t;

endpackage

// File: rtl/mbq_ptr.sv
// Wrapping pointer register for the memory buffer queue.
// The pointer is log2(DEPTH) bits wide, so natural binary overflow gives the
// modulo-DEPTH wrap for a power-of-two depth.
// Ports:
//   clk      clock, rising edge
//   reset_n  asynchronous active-low reset, pointer -> 0
//   clr      synchronous clear, takes priority over inc
//   inc      advance the pointer by one
//   ptr      current pointer value
module mbq_ptr
  import mbq_pkg::*;
#(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [Width-1:0] ptr
);

  logic [Width-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/memory_buffer_queue.sv
// Memory buffer queue: DEPTH-entry first-word-fall-through FIFO between the
// memory data bus and the CPU datapath, with valid/ready on both sides,
// synchronous flush and registered occupancy status.
// Optional feature: define MBQ_BYPASS_EN for a zero-latency combinational
// path from in_data to out_data while the queue is empty.
// Ports:
//   clk, reset_n             clock and asynchronous active-low reset
//   flush                    synchronous clear of all entries (drops any push)
//   in_data/in_valid/in_ready    producer side (memory bus)
//   out_data/out_valid/out_ready consumer side (datapath)
//   count/full/empty         registered occupancy status
module memory_buffer_queue
  import mbq_pkg::*;
#(
  parameter int unsigned DATA_W = MBQ_DATA_W,
  parameter int unsigned DEPTH  = MBQ_DEPTH,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PtrW = mbq_ptr_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_d, count_q;
  logic              full_d, full_q;
  logic              empty_d, empty_q;
  logic              bypass;
  logic              push, pop;

  // in_ready comes from registered state only; out_ready never reaches it.
  assign in_ready = !full_q;

`ifdef MBQ_BYPASS_EN
  // Empty queue: present the incoming word directly; if it is taken this
  // cycle it is never stored.
  assign bypass    = empty_q && in_valid && out_ready;
  assign out_valid = empty_q ? in_valid : 1'b1;
  assign out_data  = empty_q ? in_data : mem_q[rd_ptr];
`else
  assign bypass    = 1'b0;
  assign out_valid = !empty_q;
  assign out_data  = empty_q ? '0 : mem_q[rd_ptr];
`endif

  assign push = in_valid && in_ready && !bypass && !flush;
  // Only a stored head can be popped; a bypassed word never enters storage.
  assign pop  = !empty_q && out_ready && !flush;

  mbq_ptr #(
    .Width(PtrW)
  ) u_wr_ptr (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (flush),
    .inc    (push),
    .ptr    (wr_ptr)
  );

  mbq_ptr #(
    .Width(PtrW)
  ) u_rd_ptr (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (flush),
    .inc    (pop),
    .ptr    (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset: empty_q masks its contents until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr] <= in_data;
    end
  end

  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: tb/tb_memory_buffer_queue.sv
// Directed self-checking bench for memory_buffer_queue (DEPTH=4, DATA_W=16).
module tb_memory_buffer_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int errors = 0;
  int checks = 0;

  memory_buffer_queue #(
    .DATA_W(16),
    .DEPTH (4)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic push_one(input logic [15:0] d);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b0;
    step();
    in_valid  = 1'b0;
  endtask

  logic [15:0] model [$];
  logic [15:0] exp_w;

  initial begin
    reset_n = 1'b0;
    in_data = '0;
    idle();
    step();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    reset_n = 1'b1;
    step();

    // Asynchronous reset mid-stream with three words stored.
    push_one(16'h0A0A);
    push_one(16'h0B0B);
    push_one(16'h0C0C);
    check("pre_rst_count", count, 3);
    #1 reset_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    #1 reset_n = 1'b1;
    step();

    // First word after reset appears one edge after being pushed.
    in_valid = 1'b1;
    in_data  = 16'hA5A5;
    #1;
`ifndef MBQ_BYPASS_EN
    check("lat_pre_valid", out_valid, 0);
`endif
    step();
    in_valid = 1'b0;
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 16'hA5A5);
    check("lat_count", count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("lat_pop_empty", empty, 1);

    // Fill to full; a fifth offer is refused; drain in order.
    for (int i = 1; i <= 4; i++) push_one(16'(i));
    check("fill_full", full, 1);
    check("fill_in_ready", in_ready, 0);
    check("fill_count", count, 4);
    push_one(16'h0005);
    check("fill_5th_count", count, 4);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", out_data, 32'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_empty", empty, 1);

    // Full with push offered and pop taken: only the pop happens.
    for (int i = 0; i < 4; i++) push_one(16'h0011 + 16'(i));
    in_valid  = 1'b1;
    in_data   = 16'h0015;
    out_ready = 1'b1;
    step();
    check("full_pp_count", count, 3);
    check("full_pp_head", out_data, 16'h0012);
    in_valid = 1'b0;
    step();
    check("pop_to2_count", count, 2);
    check("pop_to2_head", out_data, 16'h0013);
    // Count 2: push and pop on one edge.
    in_valid = 1'b1;
    in_data  = 16'h0016;
    step();
    in_valid = 1'b0;
    check("pp2_count", count, 2);
    check("pp2_head", out_data, 16'h0014);
    step();
    check("pp2_next", out_data, 16'h0016);
    step();
    out_ready = 1'b0;
    check("pp2_empty", empty, 1);

    // Pointer wrap: 10 pushes alternating with pops, count between 2 and 3.
    push_one(16'h0100);
    push_one(16'h0101);
    model.push_back(16'h0100);
    model.push_back(16'h0101);
    for (int i = 2; i < 18; i++) begin
      if (i % 2 == 0) begin
        in_valid  = 1'b1;
        in_data   = 16'h0100 + 16'(i / 2 + 1);
        out_ready = 1'b0;
        model.push_back(in_data);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        exp_w = model.pop_front();
        check("wrap_data", out_data, exp_w);
      end
      step();
      check("wrap_count", count, model.size());
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (model.size() > 0) begin
      exp_w = model.pop_front();
      check("wrap_tail", out_data, exp_w);
      step();
    end
    out_ready = 1'b0;
    check("wrap_empty", empty, 1);

    // Flush with a concurrent push: everything is dropped.
    push_one(16'h0031);
    push_one(16'h0032);
    push_one(16'h0033);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0034;
    #1;
    check("flush_in_ready", in_ready, 1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_data", out_data, 0);
    push_one(16'h0035);
    check("post_flush_head", out_data, 16'h0035);
    check("post_flush_count", count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Empty queue, word offered and consumer ready.
    in_valid  = 1'b1;
    in_data   = 16'hBEEF;
    out_ready = 1'b1;
    #1;
`ifdef MBQ_BYPASS_EN
    check("byp_valid", out_valid, 1);
    check("byp_data", out_data, 16'hBEEF);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("byp_count", count, 0);
`else
    check("nobyp_pre_valid", out_valid, 0);
    step();
    in_valid  = 1'b0;
    check("nobyp_valid", out_valid, 1);
    check("nobyp_data", out_data, 16'hBEEF);
    check("nobyp_count", count, 1);
    step();
    out_ready = 1'b0;
    check("nobyp_empty", empty, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
